// File: rtl/mul6_op_seq.sv
// Operand sequencer for the 6x6 signed pipelined multiplier: queues operand pairs,
// holds each pair stable for the multiplier latency, then captures the product.
module mul6_op_seq #(
    parameter int WIDTH      = 6,
    parameter int PWIDTH     = 11,
    parameter int LATENCY    = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    output logic              mul_en,
    input  logic [PWIDTH-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PWIDTH-1:0] out_data,
    output logic              out_ovf,
    output logic [7:0]        op_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The only product that does not fit PWIDTH bits is MIN x MIN.
    function automatic logic is_min(input logic [WIDTH-1:0] v);
        return v == {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    ovf_flag_r;
    logic [WIDTH-1:0]        mul_a_r;
    logic [WIDTH-1:0]        mul_b_r;
    logic                    mul_en_r;
    logic                    out_valid_r;
    logic [PWIDTH-1:0]       out_data_r;
    logic                    out_ovf_r;
    logic [7:0]              op_count_r;

    logic [2*WIDTH-1:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [OCC_W-1:0]        occ_r;

    logic                    in_ready_s;
    logic                    fifo_empty_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    capture_s;
    logic [2*WIDTH-1:0]      head_s;

    assign in_ready_s   = (occ_r < DEPTH_C);
    assign fifo_empty_s = (occ_r == {OCC_W{1'b0}});
    assign push_s       = in_valid & in_ready_s;
    assign head_s       = fifo_mem_r[rd_ptr_r];

    // Next-state decode; a pop always coincides with loading the multiplier operands.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    state_nx_s = S_HOLD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if (cnt_r == LAT_C) begin
                    capture_s  = 1'b1;
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_HOLD;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        state_nx_s = S_HOLD;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {(2*WIDTH){1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {in_a, in_b};
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                occ_r <= occ_r + OCC_W'(1);
            end else if (pop_s && !push_s) begin
                occ_r <= occ_r - OCC_W'(1);
            end else begin
                occ_r <= occ_r;
            end
        end
    end

    // Operand registers, hold counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            ovf_flag_r  <= 1'b0;
            mul_a_r     <= {WIDTH{1'b0}};
            mul_b_r     <= {WIDTH{1'b0}};
            mul_en_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {PWIDTH{1'b0}};
            out_ovf_r   <= 1'b0;
            op_count_r  <= 8'd0;
        end else begin
            if (pop_s) begin
                mul_a_r    <= head_s[2*WIDTH-1:WIDTH];
                mul_b_r    <= head_s[WIDTH-1:0];
                ovf_flag_r <= is_min(head_s[2*WIDTH-1:WIDTH]) & is_min(head_s[WIDTH-1:0]);
                cnt_r      <= {CNT_W{1'b0}};
                mul_en_r   <= 1'b1;
            end else if (capture_s) begin
                mul_en_r <= 1'b0;
            end else if (state_r == S_HOLD) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (capture_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mul_p;
                out_ovf_r   <= ovf_flag_r;
                op_count_r  <= op_count_r + 8'd1;
            end else if ((state_r == S_DONE) && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign mul_en    = mul_en_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_mul6_op_seq.sv
// Directed bench for mul6_op_seq with a 7-stage behavioural multiplier model.
module tb_mul6_op_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_a;
    logic [5:0]  in_b;
    logic [5:0]  mul_a;
    logic [5:0]  mul_b;
    logic        mul_en;
    logic [10:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic        out_ovf;
    logic [7:0]  op_count;

    int checks = 0;
    int errors = 0;

    mul6_op_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
        .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Multiplier product only becomes correct 7 edges after the operands settle.
    logic signed [11:0] prod_s;
    logic [10:0]        mp_pipe [7];
    assign prod_s = $signed(mul_a) * $signed(mul_b);
    assign mul_p  = mp_pipe[6];
    always @(posedge clk) begin
        mp_pipe[0] <= prod_s[10:0];
        for (int i = 1; i < 7; i++) mp_pipe[i] <= mp_pipe[i-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] a, input logic [5:0] b);
        int n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        check("push_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic pop;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                              input logic [10:0] ed, input logic eovf, output int n);
        logic stable = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
            if (mul_en && (mul_a !== ea || mul_b !== eb)) stable = 1'b0;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, ed);
        check({tag, "_ovf"}, out_ovf, eovf);
        check({tag, "_hold"}, stable, 1);
    endtask

    logic [11:0] sq [$];

    initial begin
        int n;
        logic flag;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = 6'd0;
        in_b = 6'd0;
        out_ready = 1'b0;
        tick; tick;
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_en", mul_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        tick;
        check("rst_in_ready", in_ready, 1);

        // single op: 5 x -3
        push(6'd5, 6'h3D);
        check("s_no_bypass", mul_en, 0);
        tick;
        check("s_load_a", mul_a, 6'd5);
        check("s_load_b", mul_b, 6'h3D);
        check("s_mul_en", mul_en, 1);
        get_result("single", 6'd5, 6'h3D, 11'h7F1, 1'b0, n);
        check("s_latency", n, 8);
        check("s_op_count", op_count, 1);
        pop;
        check("s_pop_valid", out_valid, 0);
        check("s_idle_en", mul_en, 0);
        check("s_keep_a", mul_a, 6'd5);

        // back-pressure: one op in flight plus a full FIFO stalls the 4th pair
        push(6'd7, 6'd7);
        push(6'h38, 6'd4);
        push(6'h1F, 6'h20);
        in_a = 6'd2;
        in_b = 6'd3;
        in_valid = 1'b1;
        check("bp_stall", in_ready, 0);
        get_result("bp1", 6'd7, 6'd7, 11'h031, 1'b0, n);
        check("bp_stall2", in_ready, 0);
        pop;
        check("bp_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        get_result("bp2", 6'h38, 6'd4, 11'h7E0, 1'b0, n);
        pop;
        get_result("bp3", 6'h1F, 6'h20, 11'h420, 1'b0, n);
        pop;
        get_result("bp4", 6'd2, 6'd3, 11'h006, 1'b0, n);
        pop;

        // overflow corner
        push(6'h20, 6'h20);
        get_result("ovf", 6'h20, 6'h20, 11'h400, 1'b1, n);
        pop;
        push(6'd1, 6'd1);
        get_result("one", 6'd1, 6'd1, 11'h001, 1'b0, n);
        pop;

        // hold in DONE, next op loads on the pop edge
        push(6'd0, 6'h2F);
        push(6'd3, 6'h3B);
        get_result("zero", 6'd0, 6'h2F, 11'h000, 1'b0, n);
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (out_valid !== 1'b1 || out_data !== 11'h000) flag = 1'b0;
        end
        check("done_stable", flag, 1);
        pop;
        check("done_load_a", mul_a, 6'd3);
        check("done_load_b", mul_b, 6'h3B);
        check("done_load_en", mul_en, 1);
        check("done_pop_valid", out_valid, 0);
        get_result("after_done", 6'd3, 6'h3B, 11'h7F1, 1'b0, n);
        pop;
        check("count9", op_count, 9);

        // reset at cnt=3 with one op queued
        push(6'd9, 6'd9);
        push(6'd2, 6'd2);
        tick; tick; tick;
        rst_n = 1'b0;
        #1;
        check("mr_mul_a", mul_a, 0);
        check("mr_mul_b", mul_b, 0);
        check("mr_mul_en", mul_en, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_data", out_data, 0);
        check("mr_out_ovf", out_ovf, 0);
        check("mr_op_count", op_count, 0);
        #1;
        rst_n = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid !== 1'b0 || mul_en !== 1'b0) flag = 1'b0;
        end
        check("mr_quiet", flag, 1);
        check("mr_in_ready", in_ready, 1);

        // streaming with out_ready high
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [5:0] ra;
                    logic [5:0] rb;
                    int p;
                    logic [31:0] pv;
                    ra = 6'($urandom_range(0, 63));
                    rb = 6'($urandom_range(0, 63));
                    p = $signed(ra) * $signed(rb);
                    pv = p;
                    sq.push_back({(ra == 6'h20 && rb == 6'h20), pv[10:0]});
                    push(ra, rb);
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                int last = -1;
                int per_bad = 0;
                logic [11:0] e;
                while (got < 300 && cyc < 4000) begin
                    tick;
                    cyc++;
                    if (out_valid) begin
                        e = (sq.size() > 0) ? sq.pop_front() : 12'hFFF;
                        check("stream_res", {out_ovf, out_data}, e);
                        if (last >= 0 && cyc - last != 9) per_bad++;
                        last = cyc;
                        got++;
                    end
                end
                check("stream_cnt", got, 300);
                check("stream_period", per_bad, 0);
            end
        join
        out_ready = 1'b0;
        tick;
        check("stream_op_count", op_count, 44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
